// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle sequencer for the 16-instruction, 4-bit-opcode CPU core.
//   It walks each instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB and drives
//   the datapath control signals for one phase at a time. It also shares the
//   single memory port between instruction fetch and load/store using a
//   req/ready handshake.
//
//   Opcode map: 0000 jal, 0001 jalr, 0010 beq, 0011 ble,
//               01xx load/store (op[1] = store, op[0] = word),
//               10xx reg ALU op, 11xx immediate ALU op (op[1:0] = add/sub/and/or).
//
//   Optional feature (define MEM_TIMEOUT_EN): a memory wait counter. When it
//   reaches TIMEOUT the FSM enters HALT and raises the sticky err flag. Only
//   rst_n exits HALT. Without the define the FSM waits forever and err is 0.
//
// Ports:
//   clk, rst_n          clock (rising edge) and async active-low reset
//   en                  run enable, sampled in IDLE and on retire
//   op                  opcode from IR
//   zero, neg           ALU flags, valid in EXEC
//   mem_ready           memory completes the current request
//   mem_req, mem_we     memory request / write
//   ir_we, pc_we        IR load, PC update
//   PCsrc               00 PC+2, 01 branch, 10 jal target, 11 jalr register
//   ALUOp, alucsrc      ALU function, immediate select
//   wmem, memc          copy of mem_we, 0 byte / 1 word
//   m2reg, wreg, jal    writeback source / enable / link
//   instr_done          one-cycle retire pulse
//   err                 sticky memory timeout flag
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] op,
    input  logic       zero,
    input  logic       neg,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] PCsrc,
    output logic [2:0] ALUOp,
    output logic       alucsrc,
    output logic       wmem,
    output logic       memc,
    output logic       m2reg,
    output logic       wreg,
    output logic       jal,
    output logic       instr_done,
    output logic       err
);

`ifdef MEM_TIMEOUT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
    } state_t;
`endif

    state_t state_q, state_d;
    logic   retire;

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        PCsrc      = 2'b00;
        ALUOp      = 3'b000;
        alucsrc    = 1'b0;
        memc       = 1'b0;
        m2reg      = 1'b0;
        wreg       = 1'b0;
        jal        = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    PCsrc   = 2'b00;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // ALU ops carry their function in op[1:0]; branches compare
                // with a subtract; everything else (address calc, jumps) adds.
                if (op[3])
                    ALUOp = {1'b0, op[1:0]};
                else if (op[3:1] == 3'b001)
                    ALUOp = 3'b001;
                else
                    ALUOp = 3'b000;
                // Immediate operand for immediate ALU ops and load/store.
                alucsrc = (op[3:2] == 2'b11) || (op[3:2] == 2'b01);

                casez (op)
                    4'b000?: begin
                        wreg   = 1'b1;
                        jal    = 1'b1;
                        pc_we  = 1'b1;
                        PCsrc  = op[0] ? 2'b11 : 2'b10;
                        retire = 1'b1;
                    end
                    4'b0010: begin
                        pc_we  = zero;
                        PCsrc  = 2'b01;
                        retire = 1'b1;
                    end
                    4'b0011: begin
                        pc_we  = zero | neg;
                        PCsrc  = 2'b01;
                        retire = 1'b1;
                    end
                    4'b01??: state_d = S_MEM;
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                memc    = op[0];
                mem_we  = op[1];
                if (mem_ready) begin
                    if (op[1]) retire  = 1'b1;
                    else       state_d = S_WB;
                end
            end
            S_WB: begin
                wreg   = 1'b1;
                m2reg  = (op[3:2] == 2'b01);
                retire = 1'b1;
            end
            default: ;  // HALT: everything stays 0
        endcase

        // An instruction always completes; en only decides whether to keep going.
        if (retire) begin
            instr_done = 1'b1;
            state_d    = en ? S_FETCH : S_IDLE;
        end

`ifdef MEM_TIMEOUT_EN
        err_d = err_q;
        cnt_d = '0;
        if (mem_req && !mem_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(TIMEOUT)) begin
                state_d = S_HALT;
                err_d   = 1'b1;
            end
        end
`endif
    end

    assign wmem = mem_we;

`ifdef MEM_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed-vector bench with a scoreboard. The stimulus pushes the expected
//   per-instruction record (latency, request cycles, OR of all control outputs
//   over the instruction, outputs in the retire cycle). A monitor pops and
//   compares on every instr_done. A responder drives mem_ready after a
//   programmed number of wait cycles for the fetch and memory requests.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] op = 4'b0000;
    logic       zero = 1'b0, neg = 1'b0, mem_ready = 1'b0;
    logic       mem_req, mem_we, ir_we, pc_we, alucsrc, wmem, memc, m2reg, wreg, jal;
    logic       instr_done, err;
    logic [1:0] PCsrc;
    logic [2:0] ALUOp;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .en(en), .op(op), .zero(zero), .neg(neg),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
        .pc_we(pc_we), .PCsrc(PCsrc), .ALUOp(ALUOp), .alucsrc(alucsrc), .wmem(wmem),
        .memc(memc), .m2reg(m2reg), .wreg(wreg), .jal(jal), .instr_done(instr_done),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        int          req;
        logic [15:0] orv;
        logic [15:0] ret;
    } exp_t;

    exp_t q[$];
    int   nvec = 0, nmis = 0, ndone = 0, issued = 0;
    int   fw = 0, mw = 0;     // wait cycles for fetch / mem request
    logic hs = 1'b0, dn = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // {mem_req,mem_we,ir_we,pc_we,PCsrc,ALUOp,alucsrc,wmem,memc,m2reg,wreg,jal,err}
    function automatic logic [15:0] ev(input logic rq, we, ir, pc, input logic [1:0] ps,
                                       input logic [2:0] ao, input logic ac, wm, mc, m2, wr, jl);
        return {rq, we, ir, pc, ps, ao, ac, wm, mc, m2, wr, jl, 1'b0};
    endfunction

    function automatic logic [15:0] pk();
        return {mem_req, mem_we, ir_we, pc_we, PCsrc, ALUOp, alucsrc, wmem, memc,
                m2reg, wreg, jal, err};
    endfunction

    // Responder: phase 0 = fetch request, phase 1 = load/store request.
    int ph = 0, wc = 0;
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            ph = 0; wc = 0; mem_ready = 1'b0;
        end else begin
            if (dn)      begin ph = 0; wc = 0; end
            else if (hs) begin ph = 1; wc = 0; end
            if (mem_req) begin
                if (wc >= (ph == 1 ? mw : fw)) mem_ready = 1'b1;
                else begin mem_ready = 1'b0; wc++; end
            end else mem_ready = 1'b0;
        end
    end

    // Monitor / scoreboard.
    int          cnt = 0, rq = 0;
    logic        busy = 1'b0;
    logic [15:0] orv = '0;
    always begin
        @(negedge clk);
        #3;
        if (!rst_n) begin
            busy = 1'b0; hs = 1'b0; dn = 1'b0;
        end else begin
            hs = mem_req && mem_ready;
            dn = instr_done;
            if (!busy && mem_req) begin busy = 1'b1; cnt = 0; rq = 0; orv = '0; end
            if (busy) begin
                cnt++;
                orv |= pk();
                if (mem_req) rq++;
            end
            if (instr_done) begin
                if (q.size() == 0) chk("unexpected_retire", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("latency", cnt, e.lat);
                    chk("req_cycles", rq, e.req);
                    chk("or_outputs", int'(orv), int'(e.orv));
                    chk("retire_outputs", int'(pk()), int'(e.ret));
                end
                busy = 1'b0;
                ndone++;
            end
        end
    end

    // Drive one instruction at a negedge and wait for its retire.
    task automatic issue(input logic [3:0] o, input logic z, input logic n, input int f,
                         input int m, input int lat, input int req, input logic [15:0] ov,
                         input logic [15:0] rv, input bit drop_en);
        exp_t e;
        int   t;
        e.lat = lat; e.req = req; e.orv = ov; e.ret = rv;
        q.push_back(e);
        op = o; zero = z; neg = n; fw = f; mw = m; en = 1'b1;
        issued++;
        t = 0;
        if (drop_en) begin
            // fetch completes in one cycle, so the next negedge is DECODE
            @(negedge clk); t++;
            en = 1'b0;
        end
        do begin @(negedge clk); t++; end while (ndone < issued && t < 100);
        if (ndone < issued) begin
            chk("retire_timeout", ndone, issued);
            ndone = issued;
        end
    endtask

    initial begin
        logic [15:0] wr_only, br_or;
        wr_only = ev(0,0,0,0,2'b00,3'b000,0,0,0,0,1,0);
        br_or   = ev(1,0,1,1,2'b01,3'b001,0,0,0,0,0,0);

        #3;
        chk("reset_outputs", int'(pk()), 0);
        chk("reset_done", int'(instr_done), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_en0_outputs", int'(pk()), 0);

        // add, no waits: retires in cycle 4
        issue(4'b1000, 0, 0, 0, 0, 4, 1, ev(1,0,1,1,2'b00,3'b000,0,0,0,0,1,0), wr_only, 0);
        // lw, 2 fetch waits, 3 mem waits: retires in cycle 10
        issue(4'b0101, 0, 0, 2, 3, 10, 7, ev(1,0,1,1,2'b00,3'b000,1,0,1,1,1,0),
              ev(0,0,0,0,2'b00,3'b000,0,0,0,1,1,0), 0);
        // sb: retires in MEM, cycle 4
        issue(4'b0110, 0, 0, 0, 0, 4, 2, ev(1,1,1,1,2'b00,3'b000,1,1,0,0,0,0),
              ev(1,1,0,0,2'b00,3'b000,0,1,0,0,0,0), 0);
        // branches
        issue(4'b0011, 0, 1, 0, 0, 3, 1, br_or, ev(0,0,0,1,2'b01,3'b001,0,0,0,0,0,0), 0);
        issue(4'b0010, 0, 1, 0, 0, 3, 1, br_or, ev(0,0,0,0,2'b01,3'b001,0,0,0,0,0,0), 0);
        issue(4'b0010, 1, 0, 0, 0, 3, 1, br_or, ev(0,0,0,1,2'b01,3'b001,0,0,0,0,0,0), 0);
        issue(4'b0011, 1, 0, 0, 0, 3, 1, br_or, ev(0,0,0,1,2'b01,3'b001,0,0,0,0,0,0), 0);
        issue(4'b0011, 0, 0, 0, 0, 3, 1, br_or, ev(0,0,0,0,2'b01,3'b001,0,0,0,0,0,0), 0);
        // immediate / register ALU ops
        issue(4'b1101, 0, 0, 1, 0, 5, 2, ev(1,0,1,1,2'b00,3'b001,1,0,0,0,1,0), wr_only, 0);
        issue(4'b1111, 0, 0, 0, 0, 4, 1, ev(1,0,1,1,2'b00,3'b011,1,0,0,0,1,0), wr_only, 0);
        issue(4'b1010, 0, 0, 0, 0, 4, 1, ev(1,0,1,1,2'b00,3'b010,0,0,0,0,1,0), wr_only, 0);
        // sw, 2 mem waits
        issue(4'b0111, 0, 0, 0, 2, 6, 4, ev(1,1,1,1,2'b00,3'b000,1,1,1,0,0,0),
              ev(1,1,0,0,2'b00,3'b000,0,1,1,0,0,0), 0);
        // jal
        issue(4'b0000, 0, 0, 0, 0, 3, 1, ev(1,0,1,1,2'b10,3'b000,0,0,0,0,1,1),
              ev(0,0,0,1,2'b10,3'b000,0,0,0,0,1,1), 0);
        // long fetch wait: no timeout logic in this build, err stays 0
        issue(4'b1000, 0, 0, 6, 0, 10, 7, ev(1,0,1,1,2'b00,3'b000,0,0,0,0,1,0), wr_only, 0);
        // jalr with en dropped in DECODE: completes, then IDLE
        issue(4'b0001, 0, 0, 0, 0, 3, 1, ev(1,0,1,1,2'b11,3'b000,0,0,0,0,1,1),
              ev(0,0,0,1,2'b11,3'b000,0,0,0,0,1,1), 1);
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("idle_after_en_drop", int'(pk()), 0);
            @(negedge clk);
        end
        // restart from IDLE with lb
        issue(4'b0100, 0, 0, 0, 0, 5, 2, ev(1,0,1,1,2'b00,3'b000,1,0,0,1,1,0),
              ev(0,0,0,0,2'b00,3'b000,0,0,0,1,1,0), 0);

        // en still high: the core is now in FETCH; stall it, then reset mid-handshake
        fw = 20;
        @(negedge clk); @(negedge clk);
        #2;
        chk("fetch_req_held", int'(mem_req), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_req", int'(mem_req), 0);
        chk("async_reset_outputs", int'(pk()), 0);
        en = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", int'(pk()), 0);
        // recovery: or after reset
        issue(4'b1011, 0, 0, 0, 0, 4, 1, ev(1,0,1,1,2'b00,3'b011,0,0,0,0,1,0), wr_only, 0);

        chk("scoreboard_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
